// File: rtl/axis_pkt_pkg.sv
// Shared types and helpers for the AXI-Stream packetizer: FSM state, default
// sizing constants and the packet-length clamp.
package axis_pkt_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_DEPTH   = 1024;
  localparam int DEF_MAX_PKT = 256;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } pkt_state_e;

  // A zero or oversized request means "use the largest packet".
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_pkt);
    return (len == 0 || len > max_pkt) ? max_pkt : len;
  endfunction

endpackage

// File: rtl/axis_pkt_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered full/empty and an
// occupancy count. The head word is always visible on rd_data when not empty.
module axis_pkt_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             wr_ok, rd_ok;

  always_comb begin
    wr_ok    = wr_en & ~full_q;
    rd_ok    = rd_en & ~empty_q;
    // DEPTH is a power of two, so pointers wrap by natural overflow
    wr_ptr_d = wr_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
    full_d   = (count_d == (AW+1)'(DEPTH));
    empty_d  = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;
  assign count   = count_q;

endmodule

// File: rtl/axis_packetizer.sv
// Buffers a free-running sample stream and emits it as fixed-length AXI-Stream
// packets. Optional saturating drop counter: define AXIS_PACKETIZER_DROP_CNT_EN.
module axis_packetizer
  import axis_pkt_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int MAX_PKT = DEF_MAX_PKT
) (
  input  logic                         m00_axis_aclk,
  input  logic                         m00_axis_aresetn,
  input  logic                         din_valid,
  input  logic [WIDTH-1:0]             din,
  input  logic [$clog2(MAX_PKT+1)-1:0] pkt_len,
  input  logic                         m00_axis_tready,
  output logic                         m00_axis_tvalid,
  output logic [WIDTH-1:0]             m00_axis_tdata,
  output logic [WIDTH/8-1:0]           m00_axis_tstrb,
  output logic                         m00_axis_tlast,
  output logic [$clog2(DEPTH):0]       fill_level,
  output logic                         overflow
`ifdef AXIS_PACKETIZER_DROP_CNT_EN
  ,
  output logic [31:0]                  drop_count
`endif
);
  localparam int LW = $clog2(MAX_PKT+1);
  localparam int FW = $clog2(DEPTH) + 1;

  pkt_state_e       state_q, state_d;
  logic             tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic [LW-1:0]    len_q, len_d, beat_q, beat_d;
  logic             wr_last_q, wr_last_d, ovf_q, ovf_d;
  logic [LW-1:0]    req_len;
  logic [FW-1:0]    avail;
  logic             pkt_rdy, handshake;
  logic             fifo_wr, fifo_rd, fifo_full, fifo_empty;
  logic [WIDTH-1:0] fifo_head;
`ifdef AXIS_PACKETIZER_DROP_CNT_EN
  logic [31:0]      drop_q, drop_d;
`endif

  axis_pkt_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (m00_axis_aclk),
    .rst_n   (m00_axis_aresetn),
    .wr_en   (fifo_wr),
    .wr_data (din),
    .rd_en   (fifo_rd),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fill_level)
  );

  always_comb begin
    fifo_wr   = din_valid & ~fifo_full;
    handshake = tvalid_q & m00_axis_tready;
    fifo_rd   = handshake & ~fifo_empty;
    wr_last_d = fifo_wr;
    ovf_d     = din_valid & fifo_full;
    req_len   = LW'(clamp_len(32'(pkt_len), 32'(MAX_PKT)));
    // A word only counts toward a packet one cycle after it lands, which puts
    // the first beat two edges after the completing write.
    avail     = fill_level - FW'(wr_last_q);
    pkt_rdy   = 32'(avail) >= 32'(req_len);

    state_d  = state_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    len_d    = len_q;
    beat_d   = beat_q;

    case (state_q)
      S_IDLE: begin
        if (pkt_rdy) begin
          state_d  = S_STREAM;
          tvalid_d = 1'b1;
          len_d    = req_len;
          beat_d   = '0;
          tlast_d  = (req_len == LW'(1));
        end
      end
      S_STREAM: begin
        if (handshake) begin
          if (tlast_q) begin
            state_d  = S_IDLE;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            beat_d   = '0;
          end else begin
            beat_d  = beat_q + LW'(1);
            tlast_d = (beat_q + LW'(2) == len_q);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef AXIS_PACKETIZER_DROP_CNT_EN
    drop_d = drop_q;
    if (ovf_d && drop_q != 32'hFFFF_FFFF) drop_d = drop_q + 32'd1;
`endif
  end

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      state_q   <= S_IDLE;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      len_q     <= '0;
      beat_q    <= '0;
      wr_last_q <= 1'b0;
      ovf_q     <= 1'b0;
`ifdef AXIS_PACKETIZER_DROP_CNT_EN
      drop_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      wr_last_q <= wr_last_d;
      ovf_q     <= ovf_d;
`ifdef AXIS_PACKETIZER_DROP_CNT_EN
      drop_q    <= drop_d;
`endif
    end
  end

  // Head word is held by the FIFO until popped, so stalls keep tdata stable.
  assign m00_axis_tvalid = tvalid_q;
  assign m00_axis_tdata  = tvalid_q ? fifo_head : '0;
  assign m00_axis_tstrb  = '1;
  assign m00_axis_tlast  = tlast_q;
  assign overflow        = ovf_q;
`ifdef AXIS_PACKETIZER_DROP_CNT_EN
  assign drop_count      = drop_q;
`endif

endmodule

// File: tb/tb_axis_packetizer.sv
// Self-checking bench for axis_packetizer: scenario tasks compared against a
// timestamped queue model of the buffered samples and packet boundaries.
module tb_axis_packetizer;
  localparam int WIDTH = 32;
  localparam int DEPTH = 1024;
  localparam int MAXP  = 256;
  localparam int LW    = $clog2(MAXP+1);
  localparam int FW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0, rst_n = 1'b1, din_valid = 1'b0, tready = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic [LW-1:0] pkt_len = '0;
  logic tvalid, tlast, overflow;
  logic [WIDTH-1:0] tdata;
  logic [WIDTH/8-1:0] tstrb;
  logic [FW-1:0] fill;
`ifdef AXIS_PACKETIZER_DROP_CNT_EN
  logic [31:0] drop_count;
`endif

  always #5 clk = ~clk;

  axis_packetizer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_PKT(MAXP)) dut (
    .m00_axis_aclk    (clk),
    .m00_axis_aresetn (rst_n),
    .din_valid        (din_valid),
    .din              (din),
    .pkt_len          (pkt_len),
    .m00_axis_tready  (tready),
    .m00_axis_tvalid  (tvalid),
    .m00_axis_tdata   (tdata),
    .m00_axis_tstrb   (tstrb),
    .m00_axis_tlast   (tlast),
    .fill_level       (fill),
    .overflow         (overflow)
`ifdef AXIS_PACKETIZER_DROP_CNT_EN
    ,
    .drop_count       (drop_count)
`endif
  );

  // Reference model: buffered words with the edge number that accepted each.
  logic [WIDTH-1:0] wq[$];
  int unsigned      wt[$];
  int unsigned      cyc = 0;
  bit               m_valid = 1'b0, exp_ovf = 1'b0;
  int               m_len = 0, m_beat = 0;
  int unsigned      m_drops = 0;
  int               n_cmp = 0, n_err = 0;

  task automatic model_clear();
    wq.delete(); wt.delete();
    m_valid = 1'b0; exp_ovf = 1'b0; m_len = 0; m_beat = 0; m_drops = 0;
  endtask

  // One clock edge: apply spec rules to the inputs seen at that edge.
  task automatic step();
    bit was_valid;
    int req, elig;
    @(posedge clk);
    cyc++;
    was_valid = m_valid;
    exp_ovf = 1'b0;
    if (din_valid) begin
      if (wq.size() < DEPTH) begin wq.push_back(din); wt.push_back(cyc); end
      else begin exp_ovf = 1'b1; if (m_drops != 32'hFFFF_FFFF) m_drops++; end
    end
    if (was_valid && tready) begin
      void'(wq.pop_front()); void'(wt.pop_front());
      if (m_beat == m_len - 1) m_valid = 1'b0; else m_beat++;
    end else if (!was_valid) begin
      req = (pkt_len == 0 || int'(pkt_len) > MAXP) ? MAXP : int'(pkt_len);
      elig = 0;
      for (int i = 0; i < wt.size(); i++) begin
        if (wt[i] + 2 > cyc) break;
        elig++;
      end
      if (elig >= req) begin m_valid = 1'b1; m_len = req; m_beat = 0; end
    end
    #1;
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0; tready = 1'b1;
    repeat (n) step();
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid: got %b want 0", tvalid); end
    n_cmp++; if (tlast !== 1'b0) begin n_err++; $display("FAIL reset_tlast: got %b want 0", tlast); end
    n_cmp++; if (tdata !== '0) begin n_err++; $display("FAIL reset_tdata: got %h want 0", tdata); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_cmp++; if (fill !== '0) begin n_err++; $display("FAIL reset_fill: got %0d want 0", fill); end
`ifdef AXIS_PACKETIZER_DROP_CNT_EN
    n_cmp++; if (drop_count !== 32'd0) begin n_err++; $display("FAIL reset_drop_count: got %0d want 0", drop_count); end
`endif
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] tl_data[$];
    int phase = 0, gap = 0;
    pkt_len = LW'(4); tready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      din_valid = (i < 8); din = WIDTH'(32'h1000 + i);
      step();
      n_cmp++;
      if (tvalid !== m_valid || (m_valid && (tdata !== wq[0] || tlast !== (m_beat == m_len - 1)))) begin
        n_err++; $display("FAIL basic_beat cyc %0d: got v%b d%h l%b want v%b", cyc, tvalid, tdata, tlast, m_valid);
      end
      if (tvalid && tlast) tl_data.push_back(tdata);
      if (phase == 0 && tvalid && tlast) phase = 1;
      else if (phase == 1) begin if (tvalid) phase = 2; else gap++; end
    end
    n_cmp++; if (tl_data.size() != 2) begin n_err++; $display("FAIL basic_npkt: got %0d want 2", tl_data.size()); end
    else begin
      n_cmp++; if (tl_data[0] !== 32'h1003) begin n_err++; $display("FAIL basic_tlast0: got %h want 1003", tl_data[0]); end
      n_cmp++; if (tl_data[1] !== 32'h1007) begin n_err++; $display("FAIL basic_tlast1: got %h want 1007", tl_data[1]); end
    end
    n_cmp++; if (gap != 1) begin n_err++; $display("FAIL basic_gap: got %0d want 1", gap); end
    n_cmp++; if (tstrb !== 4'hF) begin n_err++; $display("FAIL basic_tstrb: got %h want f", tstrb); end
    idle(3);
  endtask

  task automatic test_latency();
    int beats = 0;
    bit done = 1'b0;
    pkt_len = LW'(16); tready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      din_valid = (i < 15); din = $urandom;
      step();
      n_cmp++; if (tvalid !== 1'b0) begin n_err++; $display("FAIL latency_early cyc %0d: got %b want 0", cyc, tvalid); end
    end
    din_valid = 1'b1; din = $urandom;
    step();
    din_valid = 1'b0;
    step();
    n_cmp++; if (tvalid !== 1'b0) begin n_err++; $display("FAIL latency_edge1: got %b want 0", tvalid); end
    step();
    n_cmp++; if (tvalid !== 1'b1) begin n_err++; $display("FAIL latency_edge2: got %b want 1", tvalid); end
    for (int k = 0; k < 40 && !done; k++) begin
      if (m_valid) begin
        n_cmp++; if (tdata !== wq[0]) begin n_err++; $display("FAIL latency_data: got %h want %h", tdata, wq[0]); end
      end
      if (tvalid && tready) begin beats++; if (tlast) done = 1'b1; end
      step();
    end
    n_cmp++; if (beats != 16 || !done) begin n_err++; $display("FAIL latency_beats: got %0d want 16", beats); end
    idle(3);
  endtask

  task automatic test_stall();
    int beats = 0, last_at = 0;
    bit pv, pl, pr;
    logic [WIDTH-1:0] pd;
    pkt_len = LW'(8);
    for (int i = 0; i < 50; i++) begin
      din_valid = (i < 8); din = $urandom; tready = i[0];
      pv = tvalid; pd = tdata; pl = tlast; pr = tready;
      if (tvalid && tready) begin beats++; if (tlast) last_at = beats; end
      step();
      if (pv && !pr) begin
        n_cmp++;
        if (tvalid !== 1'b1 || tdata !== pd || tlast !== pl) begin
          n_err++; $display("FAIL stall_hold cyc %0d: got v%b d%h l%b want v1 d%h l%b", cyc, tvalid, tdata, tlast, pd, pl);
        end
      end
      n_cmp++;
      if (tvalid !== m_valid || (m_valid && (tdata !== wq[0] || tlast !== (m_beat == m_len - 1)))) begin
        n_err++; $display("FAIL stall_beat cyc %0d: got v%b d%h l%b want v%b", cyc, tvalid, tdata, tlast, m_valid);
      end
    end
    n_cmp++; if (beats != 8 || last_at != 8) begin n_err++; $display("FAIL stall_count: got %0d/%0d want 8/8", beats, last_at); end
    idle(3);
  endtask

  task automatic test_clamp();
    int lens[$];
    int beats = 0;
    bit started = 1'b0;
    tready = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (tvalid) started = 1'b1;
      pkt_len = started ? LW'(5) : LW'(0);
      din_valid = (i < MAXP + 5); din = $urandom;
      if (tvalid && tready) begin beats++; if (tlast) begin lens.push_back(beats); beats = 0; end end
      step();
      n_cmp++;
      if (tvalid !== m_valid || (m_valid && (tdata !== wq[0] || tlast !== (m_beat == m_len - 1)))) begin
        n_err++; $display("FAIL clamp_beat cyc %0d: got v%b d%h l%b want v%b", cyc, tvalid, tdata, tlast, m_valid);
      end
    end
    n_cmp++;
    if (lens.size() != 2) begin n_err++; $display("FAIL clamp_npkt: got %0d want 2", lens.size()); end
    else if (lens[0] != MAXP || lens[1] != 5) begin
      n_err++; $display("FAIL clamp_lens: got %0d,%0d want %0d,5", lens[0], lens[1], MAXP);
    end
    idle(3);
  endtask

  task automatic test_overflow();
    int ovf = 0, beats = 0;
    pkt_len = LW'(0); tready = 1'b0;
    for (int i = 0; i < DEPTH + 11; i++) begin
      din_valid = (i < DEPTH + 10); din = $urandom;
      step();
      if (overflow) ovf++;
      n_cmp++; if (overflow !== exp_ovf) begin n_err++; $display("FAIL ovf_pulse cyc %0d: got %b want %b", cyc, overflow, exp_ovf); end
    end
    n_cmp++; if (fill !== FW'(DEPTH)) begin n_err++; $display("FAIL ovf_fill: got %0d want %0d", fill, DEPTH); end
    n_cmp++; if (ovf != 10) begin n_err++; $display("FAIL ovf_count: got %0d want 10", ovf); end
`ifdef AXIS_PACKETIZER_DROP_CNT_EN
    n_cmp++; if (drop_count !== 32'd10) begin n_err++; $display("FAIL ovf_drop_count: got %0d want 10", drop_count); end
`endif
    tready = 1'b1;
    for (int k = 0; k < DEPTH + 20; k++) begin
      if (tvalid) begin
        beats++;
        n_cmp++; if (!m_valid || tdata !== wq[0]) begin n_err++; $display("FAIL ovf_order beat %0d: got %h want %h", beats, tdata, wq[0]); end
      end
      step();
    end
    n_cmp++; if (beats != DEPTH || fill !== '0) begin n_err++; $display("FAIL ovf_drain: got %0d fill %0d want %0d fill 0", beats, fill, DEPTH); end
    idle(3);
  endtask

  task automatic test_reset_mid();
    logic [WIDTH-1:0] first;
    int beats = 0;
    bit hit = 1'b0, seen = 1'b0, done = 1'b0;
    pkt_len = LW'(8); tready = 1'b1;
    for (int i = 0; i < 40 && !hit; i++) begin
      din_valid = (i < 8); din = $urandom;
      step();
      if (tvalid && m_valid && m_beat == 3) hit = 1'b1;
    end
    n_cmp++; if (!hit) begin n_err++; $display("FAIL rstmid_reach: got beat %0d want 3", m_beat); end
    din_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (tvalid !== 1'b0 || tlast !== 1'b0 || tdata !== '0 || fill !== '0 || overflow !== 1'b0) begin
      n_err++; $display("FAIL rstmid_zero: got v%b l%b d%h f%0d o%b want all 0", tvalid, tlast, tdata, fill, overflow);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    model_clear();
    first = $urandom;
    for (int i = 0; i < 40 && !done; i++) begin
      din_valid = (i < 8); din = (i == 0) ? first : $urandom;
      if (tvalid && !seen) begin
        seen = 1'b1;
        n_cmp++; if (tdata !== first) begin n_err++; $display("FAIL rstmid_first: got %h want %h", tdata, first); end
      end
      if (tvalid && tready) begin beats++; if (tlast) done = 1'b1; end
      step();
    end
    n_cmp++; if (beats != 8 || !done) begin n_err++; $display("FAIL rstmid_beats: got %0d want 8", beats); end
    idle(3);
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 1500; i++) begin
      din_valid = ($urandom_range(0, 99) < 60);
      din = $urandom;
      tready = ($urandom_range(0, 99) < 70);
      r = $urandom_range(0, 39);
      pkt_len = (r == 0) ? LW'(0) : (r == 1) ? LW'(300) : LW'($urandom_range(1, 12));
      step();
      n_cmp++;
      if (tvalid !== m_valid || fill !== FW'(wq.size()) || overflow !== exp_ovf ||
          (m_valid && (tdata !== wq[0] || tlast !== (m_beat == m_len - 1)))) begin
        n_err++;
        $display("FAIL random cyc %0d: got v%b d%h l%b f%0d o%b want v%b f%0d o%b",
                 cyc, tvalid, tdata, tlast, fill, overflow, m_valid, wq.size(), exp_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latency();
    test_stall();
    test_clamp();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axis_packetizer.md
AXIS_PACKETIZER -- requirements
Module: axis_packetizer

Interface
REQ-001 Parameter WIDTH, default 32, data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 1024, buffer words; SHALL be a power of two and at least 2*MAX_PKT.
REQ-003 Parameter MAX_PKT, default 256, maximum beats per packet.
REQ-004 m00_axis_aclk  in  1  single clock for all logic; one clock, no other clock domain.
REQ-005 m00_axis_aresetn  in  1  reset, asynchronous assert, active-low.
REQ-006 din_valid  in  1  input sample strobe; no backpressure to the source.
REQ-007 din  in  WIDTH  input sample.
REQ-008 pkt_len  in  $clog2(MAX_PKT+1)  runtime packet length in beats.
REQ-009 m00_axis_tready  in  1  downstream ready.
REQ-010 m00_axis_tvalid  out  1  output beat valid.
REQ-011 m00_axis_tdata  out  WIDTH  output beat data.
REQ-012 m00_axis_tstrb  out  WIDTH/8  byte strobes.
REQ-013 m00_axis_tlast  out  1  last beat of packet.
REQ-014 fill_level  out  $clog2(DEPTH)+1  words currently buffered.
REQ-015 overflow  out  1  one-cycle pulse per dropped sample.

Function
REQ-016 Write: sample accepted when din_valid=1 and buffer not full; order preserved.
REQ-017 Full: din_valid=1 while full drops the sample, pulses overflow next cycle; full is registered, so a read in the same cycle does not admit the write.
REQ-018 pkt_len latched at packet start; 0 or >MAX_PKT clamps to MAX_PKT; changes mid-packet ignored.
REQ-019 FSM states IDLE, STREAM; IDLE->STREAM when fill_level >= latched length; STREAM->IDLE on handshake of tlast beat.
REQ-020 Latency: tvalid rises on the 2nd rising edge after the edge accepting the packet's completing word.
REQ-021 Beat counter advances only on tvalid&tready; tlast=1 exactly on beat index len-1.
REQ-022 While tvalid=1 and tready=0, tdata, tlast, tvalid held stable.
REQ-023 tvalid never deasserts mid-packet; partial packets never emitted.
REQ-024 Between packets tvalid is low for exactly one cycle (IDLE evaluation cycle).
REQ-025 tstrb constant all-ones.
REQ-026 fill_level updates the edge after each write/read; simultaneous write+read leaves it unchanged.
REQ-027 Pointers wrap modulo DEPTH with no lost or duplicated word at wrap.

Reset
REQ-028 While m00_axis_aresetn=0: tvalid=0, tlast=0, tdata=0, overflow=0, fill_level=0, FSM=IDLE, pointers and beat counter 0.
REQ-029 Reset mid-packet discards all buffered data including the partial packet; after release the first packet starts with the first post-reset sample.

Configuration
REQ-030 Macro AXIS_PACKETIZER_DROP_CNT_EN defined: adds output drop_count (32 bits, reset 0), increments per dropped sample, saturates at 0xFFFFFFFF.
REQ-031 Macro undefined: port drop_count absent; all other behaviour identical.

Structure
REQ-032 Shared package axis_pkt_pkg holds the FSM state enum, clamp-length function and default parameter constants.
REQ-033 Buffer implemented in one sub-module axis_pkt_sync_fifo (single-clock, first-word-fall-through, registered full/empty, count output).

Verification
REQ-034 pkt_len=4, write 8 samples 0x1000..0x1007, tready=1 -> two packets, tlast on 0x1003 and 0x1007, one idle cycle between.
REQ-035 pkt_len=16, write 15 samples -> tvalid stays 0; 16th sample -> tvalid high 2 edges later, 16 beats output.
REQ-036 tready=0, write DEPTH+10 samples -> fill_level=DEPTH, 10 overflow pulses, drop_count=10 when macro set; tready=1 -> DEPTH words output in order.
REQ-037 pkt_len=8, tready toggled every cycle -> data stable during stalls, 8 beats, tlast on 8th.
REQ-038 Reset asserted on beat 3 of an 8-beat packet -> outputs zero immediately; after release, first packet starts with first new sample.
REQ-039 pkt_len=0 -> packets of MAX_PKT beats; pkt_len changed mid-packet -> current packet keeps latched length.
